// File: rtl/fruit_move.sv
`default_nettype none
// ============================================================================
//  Module   : fruit_move
//  Purpose  : Per-frame motion controller for the hanging fruit object.
//             The fruit hangs at a fixed position until the player touches
//             it, then falls under constant gravity with a speed ceiling.
//             A falling fruit that hits an enemy is removed and reports one
//             enemy kill. A fruit that reaches the floor is removed with no
//             kill. After a removal the fruit stays hidden for RESPAWN_FRAMES
//             frames and then hangs again at its start position.
//  Ports    : clk              in   system clock
//             resetN           in   asynchronous active-low reset
//             startOfFrame     in   one-cycle pulse per video frame
//             pause            in   1 = freeze motion and state
//             playerHitFruit   in   player/fruit pixel collision, any cycle
//             fruitHitEnemy    in   fruit/enemy pixel collision, any cycle
//             topLeftX   [10:0] out  fruit top-left X, pixels (constant)
//             topLeftY   [10:0] out  fruit top-left Y, pixels
//             fruitVisible     out  1 unless the fruit is hidden
//             falling          out  1 while the fruit is falling
//             enemyKilledPulse out  one-clk pulse when the falling fruit
//                                   hits an enemy
//  Revision : 1.0  initial release
// ============================================================================
module fruit_move #(
    parameter logic [10:0] INITIAL_X              = 11'd280,
    parameter logic [10:0] INITIAL_Y              = 11'd185,
    parameter int          FIXED_POINT_MULTIPLIER = 64,
    parameter int          Y_ACCEL                = 4,
    parameter int          MAX_Y_SPEED            = 256,
    parameter logic [10:0] FLOOR_Y                = 11'd440,
    parameter logic [7:0]  RESPAWN_FRAMES         = 8'd120
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        startOfFrame,
    input  logic        pause,
    input  logic        playerHitFruit,
    input  logic        fruitHitEnemy,
    output logic [10:0] topLeftX,
    output logic [10:0] topLeftY,
    output logic        fruitVisible,
    output logic        falling,
    output logic        enemyKilledPulse
);

    // Sub-pixel scale is a power of two, so pixel <-> fixed-point is a shift.
    localparam int c_FP_SHIFT = $clog2(FIXED_POINT_MULTIPLIER);

    localparam logic signed [16:0] c_INITIAL_YFP = 17'({6'd0, INITIAL_Y} << c_FP_SHIFT);
    localparam logic signed [16:0] c_FLOOR_YFP   = 17'({6'd0, FLOOR_Y}   << c_FP_SHIFT);
    localparam logic [8:0]         c_Y_ACCEL     = 9'(Y_ACCEL);
    localparam logic [8:0]         c_MAX_SPEED   = 9'(MAX_Y_SPEED);

    typedef enum logic [1:0] {
        ST_HANGING = 2'd0,
        ST_FALLING = 2'd1,
        ST_HIDDEN  = 2'd2
    } state_t;

    state_t             r_state;
    logic signed [16:0] r_yFp;          // vertical position, fixed-point units
    logic [8:0]         r_speed;        // vertical speed, fixed-point units/frame
    logic [7:0]         r_counter;      // hidden frames still to go
    logic               r_hitLatch;     // player touched fruit this frame
    logic               r_enemyLatch;   // fruit touched an enemy this frame
    logic               r_visible;
    logic               r_falling;
    logic               r_enemyKilledPulse;

    logic [9:0]         w_speedSum;
    logic [8:0]         w_newSpeed;
    logic signed [16:0] w_newYFp;
    logic               w_reachedFloor;

    // ------------------------------------------------------------------------
    // Gravity step for one falling frame: accelerate with a ceiling, then move
    // by the new speed.
    // ------------------------------------------------------------------------
    always_comb begin
        w_speedSum = {1'b0, r_speed} + {1'b0, c_Y_ACCEL};
        if (w_speedSum > {1'b0, c_MAX_SPEED}) begin
            w_newSpeed = c_MAX_SPEED;
        end else begin
            w_newSpeed = w_speedSum[8:0];
        end
        w_newYFp = r_yFp + $signed({8'd0, w_newSpeed});
        // floor(y / 64) >= FLOOR_Y is the same test as y >= FLOOR_Y * 64,
        // which avoids shifting the new position down first.
        w_reachedFloor = (w_newYFp >= c_FLOOR_YFP);
    end

    // ------------------------------------------------------------------------
    // Collision latches. Collisions are pixel-level and can arrive on any
    // cycle, so they are collected over the frame and consumed at the next
    // startOfFrame. On the startOfFrame cycle itself the latch restarts with
    // only that cycle's collision, so a hit coincident with the pulse counts
    // towards the following frame. The clear happens even while paused.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_hitLatch   <= 1'b0;
            r_enemyLatch <= 1'b0;
        end else if (startOfFrame) begin
            r_hitLatch   <= r_visible & playerHitFruit;
            r_enemyLatch <= r_visible & fruitHitEnemy;
        end else begin
            r_hitLatch   <= r_hitLatch   | (r_visible & playerHitFruit);
            r_enemyLatch <= r_enemyLatch | (r_visible & fruitHitEnemy);
        end
    end

    // ------------------------------------------------------------------------
    // Motion state machine, advanced once per unpaused frame.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state            <= ST_HANGING;
            r_yFp              <= c_INITIAL_YFP;
            r_speed            <= 9'd0;
            r_counter          <= 8'd0;
            r_visible          <= 1'b1;
            r_falling          <= 1'b0;
            r_enemyKilledPulse <= 1'b0;
        end else begin
            r_enemyKilledPulse <= 1'b0;

            if (startOfFrame && !pause) begin
                case (r_state)
                    ST_HANGING: begin
                        // An enemy touching a hanging fruit is deliberately
                        // ignored; only the player can release it.
                        if (r_hitLatch) begin
                            r_state   <= ST_FALLING;
                            r_speed   <= 9'd0;
                            r_falling <= 1'b1;
                        end
                    end

                    ST_FALLING: begin
                        // An enemy hit wins over the gravity step of the
                        // same frame: the fruit disappears where it is.
                        if (r_enemyLatch) begin
                            r_state            <= ST_HIDDEN;
                            r_counter          <= RESPAWN_FRAMES;
                            r_visible          <= 1'b0;
                            r_falling          <= 1'b0;
                            r_enemyKilledPulse <= 1'b1;
                        end else begin
                            r_speed <= w_newSpeed;
                            if (w_reachedFloor) begin
                                // Park exactly on the floor line so the last
                                // reported Y is the floor, not an overshoot.
                                r_yFp     <= c_FLOOR_YFP;
                                r_state   <= ST_HIDDEN;
                                r_counter <= RESPAWN_FRAMES;
                                r_visible <= 1'b0;
                                r_falling <= 1'b0;
                            end else begin
                                r_yFp <= w_newYFp;
                            end
                        end
                    end

                    ST_HIDDEN: begin
                        // Leaving on the frame the count hits zero keeps the
                        // fruit invisible for exactly RESPAWN_FRAMES frames.
                        r_counter <= r_counter - 8'd1;
                        if (r_counter == 8'd1) begin
                            r_state   <= ST_HANGING;
                            r_yFp     <= c_INITIAL_YFP;
                            r_speed   <= 9'd0;
                            r_visible <= 1'b1;
                        end
                    end

                    default: begin
                        r_state   <= ST_HANGING;
                        r_yFp     <= c_INITIAL_YFP;
                        r_speed   <= 9'd0;
                        r_visible <= 1'b1;
                        r_falling <= 1'b0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. The pixel Y is the integer part of the fixed-point position;
    // taking the 11 bits above the fraction is the floored arithmetic shift
    // truncated to the output width.
    // ------------------------------------------------------------------------
    assign topLeftX         = INITIAL_X;
    assign topLeftY         = r_yFp[c_FP_SHIFT +: 11];
    assign fruitVisible     = r_visible;
    assign falling          = r_falling;
    assign enemyKilledPulse = r_enemyKilledPulse;

endmodule
`default_nettype wire
